// File: rtl/multdiv_unit_pkg.sv
// Shared processor constants and helpers for the iterative multiply/divide unit:
// widths, FSM state encoding, execute ALU opcodes and signed-arithmetic helpers.
package multdiv_unit_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  localparam logic [4:0]       ALU_MUL = 5'b00110;
  localparam logic [4:0]       ALU_DIV = 5'b00111;
  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Magnitude on a 33-bit path so that |INT_MIN| = 2^31 is representable.
  function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] value);
    logic [WIDTH:0] ext;
    ext = {value[WIDTH-1], value};
    if (value[WIDTH-1]) begin
      magnitude = {(WIDTH+1){1'b0}} - ext;
    end else begin
      magnitude = ext;
    end
  endfunction

  function automatic logic fits_signed(input logic [2*WIDTH-1:0] product);
    fits_signed = (&product[2*WIDTH-1:WIDTH-1]) | ~(|product[2*WIDTH-1:WIDTH-1]);
  endfunction

endpackage

// File: rtl/multdiv_unit_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor when the shifted remainder is large enough.
module div_step
  import multdiv_unit_pkg::*;
(
  input  logic [WIDTH:0] rem,
  input  logic           dividend_bit,
  input  logic [WIDTH:0] divisor,
  output logic [WIDTH:0] rem_next,
  output logic           quo_bit
);

  logic [WIDTH+1:0] shifted_s;
  logic [WIDTH+1:0] divisor_ext_s;

  // Compare-and-subtract for a single quotient bit
  always_comb begin
    shifted_s     = {rem, dividend_bit};
    divisor_ext_s = {1'b0, divisor};
    if (shifted_s >= divisor_ext_s) begin
      quo_bit  = 1'b1;
      rem_next = (WIDTH+1)'(shifted_s - divisor_ext_s);
    end else begin
      quo_bit  = 1'b0;
      rem_next = (WIDTH+1)'(shifted_s);
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit.
// 32 iterations per operation, registered result with a one-cycle ready pulse.
module multdiv_unit
  import multdiv_unit_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             is_mul_r;
  logic             booth_r;
  logic             neg_q_r;
  logic             div_zero_r;
  logic             div_ovf_r;
  // hi_r: Booth upper accumulator or division remainder; lo_r: multiplier or dividend/quotient
  logic [WIDTH:0]   hi_r;
  logic [WIDTH:0]   m_r;
  logic [WIDTH-1:0] lo_r;

  logic             start_s;
  logic [WIDTH:0]   booth_sum_s;
  logic [WIDTH:0]   hi_next_s;
  logic [WIDTH-1:0] lo_next_s;
  logic [WIDTH:0]   div_rem_s;
  logic             div_qbit_s;
  logic [2*WIDTH-1:0] product_s;
  logic [WIDTH-1:0] fin_result_s;
  logic             fin_exc_s;

  assign start_s = ctrl_MULT | ctrl_DIV;

  div_step u_div_step (
    .rem          (hi_r),
    .dividend_bit (lo_r[WIDTH-1]),
    .divisor      (m_r),
    .rem_next     (div_rem_s),
    .quo_bit      (div_qbit_s)
  );

  // Next-iteration datapath: Booth add/sub + arithmetic shift, or one divide step
  always_comb begin
    case ({lo_r[0], booth_r})
      2'b01:   booth_sum_s = hi_r + m_r;
      2'b10:   booth_sum_s = hi_r - m_r;
      default: booth_sum_s = hi_r;
    endcase
    if (is_mul_r) begin
      hi_next_s = {booth_sum_s[WIDTH], booth_sum_s[WIDTH:1]};
      lo_next_s = {booth_sum_s[0], lo_r[WIDTH-1:1]};
    end else begin
      hi_next_s = div_rem_s;
      lo_next_s = {lo_r[WIDTH-2:0], div_qbit_s};
    end
  end

  // Final result and exception from the last iteration's outputs
  always_comb begin
    product_s = {hi_next_s[WIDTH-1:0], lo_next_s};
    if (is_mul_r) begin
      fin_result_s = product_s[WIDTH-1:0];
      fin_exc_s    = ~fits_signed(product_s);
    end else if (div_zero_r) begin
      fin_result_s = {WIDTH{1'b0}};
      fin_exc_s    = 1'b1;
    end else if (neg_q_r) begin
      fin_result_s = {WIDTH{1'b0}} - lo_next_s;
      fin_exc_s    = div_ovf_r;
    end else begin
      fin_result_s = lo_next_s;
      fin_exc_s    = div_ovf_r;
    end
  end

  // Control FSM with operand latching, iteration and registered outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r        <= ST_IDLE;
      cnt_r          <= {CNT_W{1'b0}};
      is_mul_r       <= 1'b0;
      booth_r        <= 1'b0;
      neg_q_r        <= 1'b0;
      div_zero_r     <= 1'b0;
      div_ovf_r      <= 1'b0;
      hi_r           <= {(WIDTH+1){1'b0}};
      m_r            <= {(WIDTH+1){1'b0}};
      lo_r           <= {WIDTH{1'b0}};
      data_result    <= {WIDTH{1'b0}};
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          data_resultRDY <= 1'b0;
          if (start_s) begin
            state_r    <= ST_RUN;
            busy       <= 1'b1;
            cnt_r      <= {CNT_W{1'b0}};
            is_mul_r   <= ctrl_MULT;
            hi_r       <= {(WIDTH+1){1'b0}};
            booth_r    <= 1'b0;
            neg_q_r    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero_r <= (data_operandB == {WIDTH{1'b0}});
            div_ovf_r  <= (data_operandA == INT_MIN) && (data_operandB == {WIDTH{1'b1}});
            if (ctrl_MULT) begin
              m_r  <= {data_operandA[WIDTH-1], data_operandA};
              lo_r <= data_operandB;
            end else begin
              m_r  <= magnitude(data_operandB);
              lo_r <= WIDTH'(magnitude(data_operandA));
            end
          end else begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        ST_RUN: begin
          hi_r    <= hi_next_s;
          lo_r    <= lo_next_s;
          booth_r <= lo_r[0];
          cnt_r   <= cnt_r + CNT_W'(1);
          if (cnt_r == {CNT_W{1'b1}}) begin
            state_r        <= ST_DONE;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            data_result    <= fin_result_s;
            data_exception <= fin_exc_s;
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          busy           <= 1'b0;
          data_resultRDY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed self-checking bench for multdiv_unit: latency, multiply/divide
// results, exceptions, operand latching, back-to-back starts and reset abort.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  multdiv_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Called right after the start edge; pokes a DIV strobe with new operands at poke_at.
  task automatic wait_done(input string tag, input logic [31:0] er, input logic ee, input int poke_at);
    int busy_cycles;
    bit seen;
    busy_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      if (data_resultRDY) seen = 1'b1;
      else if (busy) busy_cycles++;
      if (i == poke_at) begin
        ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'd7;
      end else if (i == poke_at + 1) begin
        ctrl_DIV = 1'b0;
      end
    end
    check({tag, "_rdy"}, {31'd0, seen}, 32'd1);
    check({tag, "_busy_cycles"}, busy_cycles, 32'd32);
    check({tag, "_busy_at_rdy"}, {31'd0, busy}, 32'd0);
    check({tag, "_result"}, data_result, er);
    check({tag, "_exc"}, {31'd0, data_exception}, {31'd0, ee});
  endtask

  task automatic do_op(input string tag, input logic m, input logic d, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic ee, input int poke_at);
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = 32'hA5A5_5A5A; data_operandB = 32'h5A5A_A5A5;
    wait_done(tag, er, ee, poke_at);
  endtask

  initial begin
    bit quiet_bad;
    reset_n = 1'b0; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = 32'd0; data_operandB = 32'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_result", data_result, 32'd0);
    check("rst_exc", {31'd0, data_exception}, 32'd0);
    check("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;

    do_op("mul_7_m6", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, -1);
    @(negedge clock);
    check("hold_result", data_result, 32'hFFFF_FFD6);
    check("hold_rdy", {31'd0, data_resultRDY}, 32'd0);

    do_op("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, -1);
    do_op("mul_intmin", 1'b1, 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, -1);
    do_op("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, -1);
    do_op("div_by0", 1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1, -1);
    do_op("div_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, -1);

    // Reset mid-multiply aborts it and clears the held outputs.
    @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = 32'd9; data_operandB = 32'd9;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("midrst_result", data_result, 32'd0);
    check("midrst_exc", {31'd0, data_exception}, 32'd0);
    check("midrst_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    quiet_bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (data_resultRDY || busy) quiet_bad = 1'b1;
    end
    check("midrst_quiet", {31'd0, quiet_bad}, 32'd0);
    do_op("after_rst", 1'b1, 1'b0, 32'd2, 32'd3, 32'd6, 1'b0, -1);

    do_op("mul_ignore_div", 1'b1, 1'b0, 32'd3, 32'd5, 32'd15, 1'b0, 5);

    // Back-to-back: new multiply strobed during the DONE cycle.
    do_op("b2b_first", 1'b1, 1'b0, 32'd3, 32'd4, 32'd12, 1'b0, -1);
    ctrl_MULT = 1'b1; data_operandA = 32'hFFFF_FFFE; data_operandB = 32'd9;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0; data_operandA = 32'd0; data_operandB = 32'd0;
    wait_done("b2b_second", 32'hFFFF_FFEE, 1'b0, -1);

    do_op("both_strobes", 1'b1, 1'b1, 32'd6, 32'd7, 32'd42, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed multiply/divide unit sitting directly downstream of the execute stage.
- Execute raises isMult/isDiv with the ALU operands. This block runs a 32-iteration multiply or divide and returns a 32-bit result with an exception flag.
- The pipeline control uses busy to stall F/D/X and data_resultRDY to release the stall and write back.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 5, iteration counter width; 2**CNT_W iterations, equal to WIDTH.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
- ctrl_MULT  input  1  start a signed multiply; driven from execute isMult for one cycle.
- ctrl_DIV  input  1  start a signed divide; driven from execute isDiv for one cycle.
- data_operandA  input  32  multiplicand or dividend (execute selectedA); sampled only at start.
- data_operandB  input  32  multiplier or divisor (execute selectedB); sampled only at start.
- data_result  output  32  low 32 bits of the product, or the quotient.
- data_exception  output  1  overflow or divide-by-zero for the completed operation.
- data_resultRDY  output  1  one-cycle pulse: data_result and data_exception are valid.
- busy  output  1  operation in flight; the pipeline must stall while high.

Behaviour:
- Reset (reset_n=0 at a rising edge): state=IDLE, counter=0. All outputs 0 (data_result=0, data_exception=0, data_resultRDY=0, busy=0).
  - Reset mid-operation aborts the operation; no RDY pulse is produced for it.
- States:
  - IDLE: waiting for a start.
  - RUN: iterating, with counter 0..31.
  - DONE: a single cycle in which data_resultRDY=1.
- Start:
  - A start is accepted when ctrl_MULT|ctrl_DIV=1 at an edge while in IDLE or DONE.
  - On acceptance: latch the operands and op type, counter<=0, go to RUN.
  - If both strobes are high, multiply wins.
  - Strobes in RUN are ignored; the latched operands are unaffected.
- RUN:
  - One iteration per cycle; counter increments.
  - At counter==31 the result is finalised and the state goes to DONE.
- Latency:
  - Start sampled at edge k: busy=1 for cycles k..k+31.
  - data_resultRDY=1 in the single cycle after edge k+32; busy=0 in that cycle.
- DONE:
  - Returns to IDLE next edge unless a new start is accepted (back-to-back allowed).
- Output hold: data_result and data_exception hold their last values until the next completion.
- Multiply:
  - Radix-2 Booth on signed operands, 64-bit accumulator (hi:lo) plus a Booth bit.
  - data_result = product[31:0].
  - data_exception=1 iff product[63:31] is not all-zeros or all-ones.
- Divide:
  - Signed, truncating toward zero; the remainder is discarded.
  - Take absolute values, run a 32-step restoring divide on unsigned values, negate the quotient if the operand signs differ.
  - Divisor==0: data_result=0, data_exception=1. Latency is unchanged (still 32 iterations).
  - 0x80000000 / 0xFFFFFFFF: data_result=0x80000000, data_exception=1.
- Arithmetic:
  - Absolute value of 0x80000000 is treated as unsigned 2^31 (33-bit internal magnitude path).
  - All negation is two's complement at WIDTH bits.

Decomposition:
- Shared package (processor constants):
  - state encoding IDLE/RUN/DONE;
  - WIDTH, CNT_W;
  - execute ALU opcodes ALU_MUL=5'b00110 and ALU_DIV=5'b00111;
  - INT_MIN constant 32'h8000_0000.
- One sub-module, div_step: combinational single restoring-division iteration. Inputs: partial remainder, dividend bit, divisor. Outputs: next remainder, quotient bit.
- The Booth step stays inline in multdiv_unit.

Test Plan:
- Reset held low during a running multiply, released at edge 10 -> no RDY pulse, all outputs 0, busy=0; next start completes normally in 33 cycles.
- ctrl_MULT with A=7, B=-6 -> busy 32 cycles; then RDY pulse with result=0xFFFFFFD6, exception=0; result holds after the pulse.
- ctrl_MULT with A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1. A=0x80000000, B=1 -> result=0x80000000, exception=0.
- ctrl_DIV cases:
  - A=-7, B=2 -> result=0xFFFFFFFD (-3), exception=0.
  - A=5, B=0 -> result=0, exception=1 after the full latency.
  - A=0x80000000, B=-1 -> result=0x80000000, exception=1.
- ctrl_DIV pulsed mid-RUN of a multiply, with the operands changed in that cycle -> ignored; the multiply result uses the latched operands.
- Back-to-back starts:
  - ctrl_MULT asserted in the DONE cycle -> new op accepted, busy=1 next cycle, second RDY exactly 33 cycles later.
  - ctrl_MULT and ctrl_DIV both high -> multiply performed.
